// File: rtl/timing_loop_gear_ctrl_pkg.sv
// ============================================================================
// Package : timing_loop_pkg
// Desc    : Shared types and helpers for the symbol-timing loop gear controller.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package timing_loop_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACQ    = 2'd1,
      TRACK  = 2'd2,
      LOCKED = 2'd3
   } tlc_state_t;

   typedef logic [4:0] shift_t;

   // Magnitude of a sign-extended werr-bit value; the most negative code
   // saturates to the largest positive code so it still fits in werr-1 bits.
   function automatic logic [63:0] abs_sat(input logic signed [63:0] e,
                                           input int unsigned         werr);
      logic signed [63:0] w_min;
      logic [63:0]        w_max;
      w_min = -(64'sd1 <<< (werr - 1));
      w_max = (64'd1 << (werr - 1)) - 64'd1;
      if (e == w_min)
         return w_max;
      else if (e < 64'sd0)
         return -e;
      else
         return e;
   endfunction

endpackage

`default_nettype wire

// File: rtl/timing_loop_gear_ctrl_lock_metric_win.sv
// ============================================================================
// Module : lock_metric_win
// Desc   : Windowed sum of |e| with end-of-window good/bad classification.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lock_metric_win
   import timing_loop_pkg::*;
#(
   parameter int WERR          = 18,
   parameter int LOCK_WIN_LOG2 = 6,
   parameter int LOCK_THR      = 64,
   parameter int UNLOCK_THR    = 512,
   parameter bit DB_EN         = 1'b0,
   parameter int DB_THR        = 128
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   i_clear,
   input  logic                   i_run,
   input  logic                   i_valid,
   input  logic signed [WERR-1:0] i_e,
   output logic                   o_win_done,
   output logic                   o_good,
   output logic                   o_bad
);

   localparam int              SUM_W        = WERR + LOCK_WIN_LOG2;
   localparam logic [WERR-1:0] c_lock_thr   = WERR'(LOCK_THR);
   localparam logic [WERR-1:0] c_unlock_thr = WERR'(UNLOCK_THR);
   localparam logic [WERR-1:0] c_db_thr     = WERR'(DB_THR);

   logic [SUM_W-1:0]         r_sum;
   logic [LOCK_WIN_LOG2-1:0] r_cnt;

   logic [WERR-1:0]  w_abs;
   logic [WERR-1:0]  w_contrib;
   logic [WERR-1:0]  w_mean;
   logic [SUM_W-1:0] w_sum_nxt;
   logic             w_take;

   // The completing strobe is folded into the window before it is judged.
   always_comb begin
      w_abs      = WERR'(abs_sat(64'(i_e), WERR));
      w_contrib  = (DB_EN && (w_abs < c_db_thr)) ? '0 : w_abs;
      w_take     = i_run && i_valid;
      w_sum_nxt  = r_sum + SUM_W'(w_contrib);
      w_mean     = WERR'(w_sum_nxt >> LOCK_WIN_LOG2);
      o_win_done = w_take && (r_cnt == '1);
      o_good     = o_win_done && (w_mean < c_lock_thr);
      o_bad      = o_win_done && (w_mean > c_unlock_thr);
   end

   always_ff @(posedge clk) begin
      if (!reset_n || i_clear) begin
         r_sum <= '0;
         r_cnt <= '0;
      end else if (w_take) begin
         r_cnt <= r_cnt + 1'b1;
         r_sum <= o_win_done ? '0 : w_sum_nxt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/timing_loop_gear_ctrl.sv
// ============================================================================
// Module : timing_loop_gear_ctrl
// Desc   : ACQ/TRACK gain gear-shift and lock FSM for the symbol-timing PI loop.
//          Build option TLC_DEADBAND_EN zeroes small |e| in the lock metric.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module timing_loop_gear_ctrl
   import timing_loop_pkg::*;
#(
   parameter int WERR           = 18,
   parameter int KP_ACQ         = 5,
   parameter int KI_ACQ         = 10,
   parameter int KP_TRK         = 7,
   parameter int KI_TRK         = 12,
   parameter int ACQ_SYMS       = 256,
   parameter int LOCK_WIN_LOG2  = 6,
   parameter int LOCK_THR       = 64,
   parameter int UNLOCK_THR     = 512,
   parameter int LOCK_CONFIRM   = 4,
   parameter int UNLOCK_CONFIRM = 2,
   parameter int DEADBAND       = 128
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable_i,
   input  logic signed [WERR-1:0] e_in_i,
   input  logic                   e_valid_i,
   output logic [4:0]             kp_shift_o,
   output logic [4:0]             ki_shift_o,
   output logic                   acc_clr_o,
   output logic                   locked_o,
   output logic [1:0]             state_o
);

   localparam int SYM_W  = $clog2(ACQ_SYMS + 1);
   localparam int GOOD_W = $clog2(LOCK_CONFIRM + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CONFIRM + 1);

   localparam logic [SYM_W-1:0]  c_sym_last  = SYM_W'(ACQ_SYMS - 1);
   localparam logic [GOOD_W-1:0] c_good_last = GOOD_W'(LOCK_CONFIRM - 1);
   localparam logic [BAD_W-1:0]  c_bad_last  = BAD_W'(UNLOCK_CONFIRM - 1);

   localparam shift_t c_kp_acq = shift_t'(KP_ACQ);
   localparam shift_t c_ki_acq = shift_t'(KI_ACQ);
   localparam shift_t c_kp_trk = shift_t'(KP_TRK);
   localparam shift_t c_ki_trk = shift_t'(KI_TRK);

`ifdef TLC_DEADBAND_EN
   localparam bit c_db_en = 1'b1;
`else
   localparam bit c_db_en = 1'b0;
`endif

   tlc_state_t        r_state;
   tlc_state_t        w_next;
   logic [SYM_W-1:0]  r_sym;
   logic [GOOD_W-1:0] r_good;
   logic [BAD_W-1:0]  r_bad;

   logic w_run;
   logic w_clear;
   logic w_win_done;
   logic w_good;
   logic w_bad;

   lock_metric_win #(
      .WERR          (WERR),
      .LOCK_WIN_LOG2 (LOCK_WIN_LOG2),
      .LOCK_THR      (LOCK_THR),
      .UNLOCK_THR    (UNLOCK_THR),
      .DB_EN         (c_db_en),
      .DB_THR        (DEADBAND)
   ) u_metric (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_clear    (w_clear),
      .i_run      (w_run),
      .i_valid    (e_valid_i),
      .i_e        (e_in_i),
      .o_win_done (w_win_done),
      .o_good     (w_good),
      .o_bad      (w_bad)
   );

   // Disable beats every other transition; any state change restarts all counts.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (enable_i) w_next = ACQ;
         ACQ:     if (e_valid_i && (r_sym == c_sym_last)) w_next = TRACK;
         TRACK:   if (w_good && (r_good == c_good_last)) w_next = LOCKED;
         LOCKED:  if (w_bad && (r_bad == c_bad_last)) w_next = ACQ;
         default: w_next = IDLE;
      endcase
      if (!enable_i)
         w_next = IDLE;
      w_clear = (w_next != r_state);
      w_run   = (r_state == TRACK) || (r_state == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         state_o    <= IDLE;
         kp_shift_o <= c_kp_acq;
         ki_shift_o <= c_ki_acq;
         acc_clr_o  <= 1'b1;
         locked_o   <= 1'b0;
         r_sym      <= '0;
         r_good     <= '0;
         r_bad      <= '0;
      end else begin
         r_state    <= w_next;
         state_o    <= w_next;
         kp_shift_o <= ((w_next == TRACK) || (w_next == LOCKED)) ? c_kp_trk : c_kp_acq;
         ki_shift_o <= ((w_next == TRACK) || (w_next == LOCKED)) ? c_ki_trk : c_ki_acq;
         locked_o   <= (w_next == LOCKED);
         // Held in IDLE; a single-cycle flush when lock is lost.
         acc_clr_o  <= (w_next == IDLE) || ((r_state == LOCKED) && (w_next == ACQ));
         if (w_clear) begin
            r_sym  <= '0;
            r_good <= '0;
            r_bad  <= '0;
         end else begin
            if ((r_state == ACQ) && e_valid_i)
               r_sym <= r_sym + 1'b1;
            if ((r_state == TRACK) && w_win_done)
               r_good <= w_good ? r_good + 1'b1 : '0;
            if ((r_state == LOCKED) && w_win_done)
               r_bad <= w_bad ? r_bad + 1'b1 : '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_timing_loop_gear_ctrl.sv
// ============================================================================
// Module : tb_timing_loop_gear_ctrl
// Desc   : Scoreboard bench for timing_loop_gear_ctrl; expected output changes
//          are queued by the stimulus and checked by a negedge monitor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_timing_loop_gear_ctrl;

   typedef struct packed {
      logic [1:0] st;
      logic [4:0] kp;
      logic [4:0] ki;
      logic       clr;
      logic       lk;
   } obs_t;

   typedef struct {
      obs_t  o;
      int    cyc;
      string nm;
   } sb_t;

   localparam obs_t X_IDLE = '{st:2'd0, kp:5'd5, ki:5'd10, clr:1'b1, lk:1'b0};
   localparam obs_t X_ACQ  = '{st:2'd1, kp:5'd5, ki:5'd10, clr:1'b0, lk:1'b0};
   localparam obs_t X_ACQC = '{st:2'd1, kp:5'd5, ki:5'd10, clr:1'b1, lk:1'b0};
   localparam obs_t X_TRK  = '{st:2'd2, kp:5'd7, ki:5'd12, clr:1'b0, lk:1'b0};
   localparam obs_t X_LCK  = '{st:2'd3, kp:5'd7, ki:5'd12, clr:1'b0, lk:1'b1};

   logic               clk       = 1'b0;
   logic               reset_n   = 1'b0;
   logic               enable_i  = 1'b0;
   logic signed [17:0] e_in_i    = '0;
   logic               e_valid_i = 1'b0;
   logic [4:0]         kp_shift_o;
   logic [4:0]         ki_shift_o;
   logic               acc_clr_o;
   logic               locked_o;
   logic [1:0]         state_o;

   sb_t  q[$];
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;
   obs_t prev  = '0;

   timing_loop_gear_ctrl #(
      .WERR           (18),
      .KP_ACQ         (5),
      .KI_ACQ         (10),
      .KP_TRK         (7),
      .KI_TRK         (12),
      .ACQ_SYMS       (16),
      .LOCK_WIN_LOG2  (3),
      .LOCK_THR       (100),
      .UNLOCK_THR     (400),
      .LOCK_CONFIRM   (2),
      .UNLOCK_CONFIRM (2),
      .DEADBAND       (128)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .enable_i   (enable_i),
      .e_in_i     (e_in_i),
      .e_valid_i  (e_valid_i),
      .kp_shift_o (kp_shift_o),
      .ki_shift_o (ki_shift_o),
      .acc_clr_o  (acc_clr_o),
      .locked_o   (locked_o),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Every change of the output bundle must match the next queued expectation.
   always @(negedge clk) begin : mon
      obs_t cur;
      sb_t  s;
      cur = '{st:state_o, kp:kp_shift_o, ki:ki_shift_o, clr:acc_clr_o, lk:locked_o};
      if (cur !== prev) begin
         n_vec++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected: got st=%0d kp=%0d ki=%0d clr=%0d lk=%0d @%0d, want no change",
                     cur.st, cur.kp, cur.ki, cur.clr, cur.lk, cyc);
         end else begin
            s = q.pop_front();
            if ((cur !== s.o) || (cyc != s.cyc)) begin
               n_err++;
               $display("FAIL %s: got st=%0d kp=%0d ki=%0d clr=%0d lk=%0d @%0d, want st=%0d kp=%0d ki=%0d clr=%0d lk=%0d @%0d",
                        s.nm, cur.st, cur.kp, cur.ki, cur.clr, cur.lk, cyc,
                        s.o.st, s.o.kp, s.o.ki, s.o.clr, s.o.lk, s.cyc);
            end
         end
      end
      prev = cur;
   end

   task automatic drive(input logic en, input logic v, input logic signed [17:0] e);
      enable_i  = en;
      e_valid_i = v;
      e_in_i    = e;
      @(posedge clk);
      #1;
      e_valid_i = 1'b0;
   endtask

   task automatic expect_at(input obs_t o, input int dc, input string nm);
      sb_t s;
      s.o   = o;
      s.cyc = cyc + dc;
      s.nm  = nm;
      q.push_back(s);
   endtask

   task automatic gap();
      repeat (3) drive(1'b1, 1'b0, 18'sd0);
   endtask

   // n strobes alternating ea/eb, one every 4 cycles; optionally an expected
   // output change on the edge that samples the last strobe.
   task automatic run_win(input logic signed [17:0] ea, input logic signed [17:0] eb,
                          input int n, input bit last_exp, input obs_t o, input string nm);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 1'b1, (i % 2 == 0) ? ea : eb);
         if (last_exp && (i == n - 1))
            expect_at(o, 0, nm);
         gap();
      end
   endtask

   initial begin : stim
      sb_t s;
      expect_at(X_IDLE, 1, "reset");
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;

      drive(1'b1, 1'b0, 18'sd0);
      expect_at(X_ACQ, 0, "enable");
      run_win(18'sd0, 18'sd0, 16, 1'b1, X_TRK, "acq_to_trk");

      run_win(18'sd50, -18'sd50, 16, 1'b1, X_LCK, "lock");

      run_win(-18'sd600, -18'sd600, 15, 1'b0, X_LCK, "");
      drive(1'b1, 1'b1, -18'sd600);
      expect_at(X_ACQC, 0, "unlock");
      expect_at(X_ACQ, 1, "unlock_clr_end");
      gap();

      run_win(18'sd0, 18'sd0, 16, 1'b1, X_TRK, "reacq");
      run_win(18'sd50, -18'sd50, 8, 1'b0, X_LCK, "");
      run_win(18'sd200, -18'sd200, 8, 1'b0, X_LCK, "");
      run_win(18'sd50, -18'sd50, 16, 1'b1, X_LCK, "lock_after_mid");

      run_win(18'sd50, -18'sd50, 3, 1'b0, X_LCK, "");
      drive(1'b0, 1'b1, -18'sd600);
      expect_at(X_IDLE, 0, "disable");
      drive(1'b0, 1'b0, 18'sd0);
      drive(1'b0, 1'b0, 18'sd0);
      drive(1'b1, 1'b0, 18'sd0);
      expect_at(X_ACQ, 0, "reenable");
      run_win(18'sd0, 18'sd0, 16, 1'b1, X_TRK, "full_acq");

      run_win(18'sh20000, 18'sh20000, 8, 1'b0, X_LCK, "");
      run_win(18'sd50, -18'sd50, 8, 1'b0, X_LCK, "");
      run_win(18'sd100, -18'sd100, 8, 1'b0, X_LCK, "");
      run_win(18'sd50, -18'sd50, 16, 1'b1, X_LCK, "lock_after_thr");

      drive(1'b0, 1'b0, 18'sd0);
      expect_at(X_IDLE, 0, "final_disable");

      for (int i = 0; (i < 20) && (q.size() != 0); i++) @(posedge clk);
      repeat (2) @(posedge clk);
      while (q.size() != 0) begin
         s = q.pop_front();
         n_vec++;
         n_err++;
         $display("FAIL %s: got no output change, want st=%0d kp=%0d ki=%0d clr=%0d lk=%0d @%0d",
                  s.nm, s.o.st, s.o.kp, s.o.ki, s.o.clr, s.o.lk, s.cyc);
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/timing_loop_gear_ctrl.md
# timing_loop_gear_ctrl

Gear-shift and lock controller for the symbol-timing PI loop filter in the MSK demodulator. It watches the Gardner TED error stream and the loop-filter strobe, and selects wide acquisition gains or narrow tracking gains by driving the filter's proportional/integral shift amounts. It declares lock from a windowed mean of |error|, and clears the filter integrator when lock is lost or the loop is disabled. It sits between the TED and the PI loop filter and owns the loop-filter configuration.

## Interface
- WERR, 18: width of e_in_i
- KP_ACQ, 5: proportional shift in ACQ
- KI_ACQ, 10: integral shift in ACQ
- KP_TRK, 7: proportional shift in TRACK/LOCKED
- KI_TRK, 12: integral shift in TRACK/LOCKED
- ACQ_SYMS, 256: error strobes spent in ACQ, ≥1
- LOCK_WIN_LOG2, 6: metric window = 2^LOCK_WIN_LOG2 strobes
- LOCK_THR, 64: mean |e| strictly below this counts as a good window
- UNLOCK_THR, 512: mean |e| strictly above this counts as a bad window
- LOCK_CONFIRM, 4: consecutive good windows to lock
- UNLOCK_CONFIRM, 2: consecutive bad windows to unlock
- DEADBAND, 128: metric deadband, used only with TLC_DEADBAND_EN

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- enable_i  in  1  loop enable, level
- e_in_i  in  WERR  signed timing error from TED
- e_valid_i  in  1  one-cycle error strobe
- kp_shift_o  out  5  proportional shift to loop filter
- ki_shift_o  out  5  integral shift to loop filter
- acc_clr_o  out  1  integrator clear to loop filter
- locked_o  out  1  timing lock
- state_o  out  2  IDLE=0, ACQ=1, TRACK=2, LOCKED=3

## Operation
- |e| computation: |−2^(WERR−1)| saturates to 2^(WERR−1)−1.
- Window sum width: WERR+LOCK_WIN_LOG2 bits, unsigned. Mean = sum >> LOCK_WIN_LOG2, truncating.
- Counters advance only on e_valid_i. Strobes are ignored in IDLE.
- IDLE: acc_clr_o=1, gains=ACQ.
  - enable_i=1 → ACQ.
- ACQ: gains=ACQ. Symbol counter counts strobes.
  - On the ACQ_SYMS-th strobe → TRACK.
- TRACK: gains=TRK. Window metric runs.
  - Each good window increments the good count. Any non-good window zeroes it.
  - Good count reaches LOCK_CONFIRM → LOCKED.
- LOCKED: gains=TRK, locked_o=1.
  - Bad windows increment the bad count. Any non-bad window zeroes it.
  - Bad count reaches UNLOCK_CONFIRM → ACQ, with a one-cycle acc_clr_o pulse.
- enable_i=0 in any state → IDLE the next cycle. This has priority over every other transition.
- Every state transition zeroes the window sum, window counter, symbol counter, and good/bad counts.
- A transition is taken on the same edge that registers the completing strobe. That strobe's |e| belongs to the completed window.

## Timing
- All outputs are registered.
- Reset values: state_o=0, kp_shift_o=KP_ACQ, ki_shift_o=KI_ACQ, acc_clr_o=1, locked_o=0.
- kp_shift_o, ki_shift_o, locked_o and state_o change on the same edge as the state register, derived from next-state.
- Decision latency: strobe completing a window or ACQ count at edge n → new state visible after edge n+1 (one cycle).
- acc_clr_o:
  - Level while in IDLE.
  - Exactly one cycle on LOCKED→ACQ, coincident with state_o=1.
- Minimum strobe spacing is 1 cycle, so back-to-back e_valid_i is supported. A strobe in the same cycle as enable_i falling is discarded.
- Reset mid-operation: reset overrides all inputs. The next cycle shows reset values.

## Configuration
- TLC_DEADBAND_EN defined: |e| < DEADBAND contributes 0 to the window sum. This suppresses TED quantization jitter in the lock metric.
- TLC_DEADBAND_EN undefined: raw |e| is accumulated and the DEADBAND parameter is unused.
- Gain selection and state sequencing are identical in both builds.

## Structure
- Package timing_loop_pkg:
  - state enum tlc_state_t {IDLE, ACQ, TRACK, LOCKED}
  - typedef shift_t (5-bit)
  - function abs_sat(e) for WERR-generic saturating magnitude
- Sub-module lock_metric_win holds the sum register, window counter, and end-of-window compare. Its outputs are win_done, good, bad, with a clear input. The FSM and gain mux stay in the top.

## Test plan
Bench parameters: ACQ_SYMS=16, LOCK_WIN_LOG2=3, LOCK_THR=100, UNLOCK_THR=400, LOCK_CONFIRM=2, UNLOCK_CONFIRM=2, strobe every 4 cycles.

1. Reset, then enable_i=1 → ACQ with kp=5, ki=10. After the 16th strobe → TRACK with kp=7, ki=12 one cycle later. acc_clr_o=0 from the ACQ entry onward.
2. In TRACK, 16 strobes alternating e=+50/−50 → locked_o=1 and state_o=3 one cycle after the 16th strobe.
3. Good window, then a window of |e|=200, then two good windows → no lock until the 4th window completes.
4. In LOCKED, 16 strobes of e=−600 → state_o=1 and acc_clr_o high for exactly one cycle, both after the 16th strobe. kp returns to 5 on that same edge.
5. e_in_i=−131072 for 8 strobes in TRACK → mean 131071, no overflow, window is bad, no lock.
6. enable_i dropped mid-window while LOCKED with a simultaneous strobe → IDLE next cycle, acc_clr_o held. Re-enable restarts ACQ with a full 16-strobe count.
